lc3_ctrl_seq: RTL and testbench
===============================

Name: lc3_ctrl_seq

Overview:
Multi-cycle control sequencer for the LC3 core. It steps the fetch, decode, execute, memory and writeback blocks through each instruction and drives their enables. It generates br_taken for the fetch block, and handles the instruction-memory and data-memory completion handshakes. Each wait on memory has an optional timeout.

Parameters:
TIMEOUT, 255, max cycles spent in any wait state before abort; 0 disables the timeout; legal range 0..255.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
complete_instr  in  1  instruction memory done; sampled in FETCH
complete_data  in  1  data memory done; sampled in MEM_IND/MEM_RD/MEM_WR
ir  in  16  instruction from decode; valid in DECODE cycle
nzp  in  3  current PSR condition codes; sampled in EXECUTE
enable_fetch  out  1  high in FETCH
enable_decode  out  1  high in DECODE
enable_execute  out  1  high in EXECUTE
enable_writeback  out  1  high in WRITEBACK
enable_updatePC  out  1  high in UPDATE_PC
br_taken  out  1  branch/jump redirect; valid only in UPDATE_PC
mem_state  out  2  00 read-indirect, 01 read, 10 write, 11 idle
ctrl_state  out  3  current state encoding, for debug/monitor
timeout_err  out  1  one-cycle pulse when a wait state aborts

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, MEM_IND=4, MEM_RD=5, MEM_WR=6, UPDATE_PC=7.
- Reset (rst low, asynchronous):
  - state=FETCH, run=0, br_taken=0, timeout_err=0, wait counter=0, opcode latch=0.
  - run gates all enable_* outputs to 0 and forces mem_state=11.
  - run sets on the first posedge after rst deasserts. FETCH is therefore active from the second edge.
  - Reset mid-instruction abandons the instruction. Nothing is written back.
- Outputs are Moore: decoded from the registered state and run only. No combinational path from any input to any output.
- FETCH: wait for complete_instr=1, then go to DECODE.
- DECODE: one cycle. Latch ir[15:12] as opcode, ir[11:9] as cond. Go to EXECUTE.
- EXECUTE: one cycle. Next state depends on opcode:
  - ADD 0001, AND 0101, NOT 1001, LEA 1110 -> WRITEBACK.
  - LD 0010, LDR 0110 -> MEM_RD.
  - LDI 1010 -> MEM_IND.
  - ST 0011, STR 0111 -> MEM_WR.
  - STI 1011 -> MEM_IND.
  - BR 0000 -> UPDATE_PC; register br_taken = |(cond & nzp).
  - JMP 1100 -> UPDATE_PC; register br_taken = 1.
  - All other opcodes -> UPDATE_PC with br_taken=0 (executed as NOP).
- MEM_IND: on complete_data go to MEM_RD for LDI, or MEM_WR for STI.
- MEM_RD: on complete_data go to WRITEBACK.
- MEM_WR: on complete_data go to UPDATE_PC.
- WRITEBACK: one cycle, then UPDATE_PC.
- UPDATE_PC: one cycle, then FETCH. br_taken clears on leaving UPDATE_PC.
- complete_* are ignored outside their own wait states.
- Wait counter:
  - 8-bit. Clears on entry to any wait state (FETCH, MEM_IND, MEM_RD, MEM_WR).
  - Increments each cycle the state's complete input is 0.
- Timeout (TIMEOUT != 0), when counter == TIMEOUT-1 and complete is still 0:
  - timeout_err pulses on the next cycle.
  - From FETCH: stay in FETCH and restart the count (refetch).
  - From a MEM state: go to UPDATE_PC with br_taken=0, skipping writeback.
  - If complete and the timeout condition occur in the same cycle, complete wins.
- Minimum instruction latencies, with memory completing in the first wait cycle:
  - ALU: 5 cycles.
  - LD: 6 cycles. LDI: 7 cycles.
  - ST: 5 cycles. STI: 6 cycles.
  - BR: 4 cycles.

Optional Feature:
Macro LC3_CTRL_PERF_EN.
- When defined:
  - Adds outputs instr_count[15:0] and stall_count[15:0], both reset to 0.
  - instr_count increments on every exit from UPDATE_PC and wraps 0xFFFF -> 0.
  - stall_count increments each wait-state cycle with complete=0, and saturates at 0xFFFF.
- When undefined: neither port nor any counter logic exists. Core behaviour is identical.

Test Plan:
- Reset release, complete_instr held 1, ir=16'h1261 (ADD): ctrl_state 0,1,2,3,7,0 on successive cycles. enable_writeback high exactly 1 cycle. br_taken=0.
- BRz (ir=16'h0405) with nzp=010: br_taken=1 during UPDATE_PC. Same instruction with nzp=100: br_taken=0.
- LDI (ir=16'hA402) with complete_data delayed 3 cycles in each of MEM_IND and MEM_RD:
  - mem_state reads 00 for 4 cycles, then 01 for 4 cycles.
  - Then WRITEBACK, then UPDATE_PC.
- STI (ir=16'hB402), complete_data=1 immediately: mem_state 00 then 10. enable_writeback never asserted.
- TIMEOUT=4, LD with complete_data=0:
  - timeout_err pulses once after 4 MEM_RD cycles, then UPDATE_PC. No WRITEBACK.
  - Separately: complete_data=1 in the 4th cycle gives no error.
- Assert rst during MEM_WR:
  - All enables drop to 0 immediately; mem_state=11.
  - After release, one idle cycle, then FETCH. With LC3_CTRL_PERF_EN, instr_count=0.

Source files
------------

// File: rtl/lc3_ctrl_seq_if.sv
// Handshake/control bundle between the LC3 control sequencer (master) and the
// fetch/decode/execute/memory/writeback datapath blocks (slave).
interface lc3_ctrl_seq_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        enable_updatePC;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic [2:0]  ctrl_state;
  logic        timeout_err;

  modport master (
    input  complete_instr, complete_data, ir, nzp,
    output enable_fetch, enable_decode, enable_execute, enable_writeback,
           enable_updatePC, br_taken, mem_state, ctrl_state, timeout_err
  );

  modport slave (
    output complete_instr, complete_data, ir, nzp,
    input  enable_fetch, enable_decode, enable_execute, enable_writeback,
           enable_updatePC, br_taken, mem_state, ctrl_state, timeout_err
  );
endinterface

// File: rtl/lc3_ctrl_seq.sv
// LC3 multi-cycle control sequencer with per-wait-state memory timeout.
// Optional macro LC3_CTRL_PERF_EN adds instr_count/stall_count performance counters.
module lc3_ctrl_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  lc3_ctrl_seq_if.master    bus
`ifdef LC3_CTRL_PERF_EN
  ,
  output logic [15:0]       instr_count,
  output logic [15:0]       stall_count
`endif
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    MEM_IND   = 3'd4,
    MEM_RD    = 3'd5,
    MEM_WR    = 3'd6,
    UPDATE_PC = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000,
    OP_ADD = 4'b0001,
    OP_LD  = 4'b0010,
    OP_ST  = 4'b0011,
    OP_AND = 4'b0101,
    OP_LDR = 4'b0110,
    OP_STR = 4'b0111,
    OP_NOT = 4'b1001,
    OP_LDI = 4'b1010,
    OP_STI = 4'b1011,
    OP_JMP = 4'b1100,
    OP_LEA = 4'b1110
  } opcode_t;

  localparam logic       TMO_EN  = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LIM = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_t     state;
  logic       run;
  logic       br_q;
  logic       tmo_q;
  logic [7:0] wcnt;
  logic [3:0] opcode;
  logic [2:0] cond;

  logic       in_wait;
  logic       wait_done;
  logic       tmo_hit;
  logic       unused_ir;

  assign unused_ir = ^bus.ir[8:0];

  // Each wait state listens only to its own completion input.
  always_comb begin
    in_wait   = 1'b0;
    wait_done = 1'b0;
    case (state)
      FETCH: begin
        in_wait   = 1'b1;
        wait_done = bus.complete_instr;
      end
      MEM_IND, MEM_RD, MEM_WR: begin
        in_wait   = 1'b1;
        wait_done = bus.complete_data;
      end
      default: ;
    endcase
  end

  assign tmo_hit = TMO_EN && in_wait && !wait_done && (wcnt == TMO_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= FETCH;
      run    <= 1'b0;
      br_q   <= 1'b0;
      tmo_q  <= 1'b0;
      wcnt   <= '0;
      opcode <= '0;
      cond   <= '0;
    end else begin
      tmo_q <= 1'b0;
      if (!run) begin
        run <= 1'b1;
      end else begin
        if (in_wait && !wait_done)
          wcnt <= wcnt + 8'd1;
        // Every transition into a wait state below also clears wcnt, overriding the increment.
        case (state)
          FETCH: begin
            if (wait_done) begin
              state <= DECODE;
            end else if (tmo_hit) begin
              tmo_q <= 1'b1;
              wcnt  <= '0;
            end
          end
          DECODE: begin
            opcode <= bus.ir[15:12];
            cond   <= bus.ir[11:9];
            state  <= EXECUTE;
          end
          EXECUTE: begin
            wcnt <= '0;
            case (opcode)
              OP_ADD, OP_AND, OP_NOT, OP_LEA: state <= WRITEBACK;
              OP_LD, OP_LDR:                  state <= MEM_RD;
              OP_LDI, OP_STI:                 state <= MEM_IND;
              OP_ST, OP_STR:                  state <= MEM_WR;
              OP_BR: begin
                state <= UPDATE_PC;
                br_q  <= |(cond & bus.nzp);
              end
              OP_JMP: begin
                state <= UPDATE_PC;
                br_q  <= 1'b1;
              end
              default:                        state <= UPDATE_PC;
            endcase
          end
          MEM_IND: begin
            if (wait_done) begin
              state <= (opcode == OP_LDI) ? MEM_RD : MEM_WR;
              wcnt  <= '0;
            end else if (tmo_hit) begin
              tmo_q <= 1'b1;
              state <= UPDATE_PC;
            end
          end
          MEM_RD: begin
            if (wait_done) begin
              state <= WRITEBACK;
            end else if (tmo_hit) begin
              tmo_q <= 1'b1;
              state <= UPDATE_PC;
            end
          end
          MEM_WR: begin
            if (wait_done) begin
              state <= UPDATE_PC;
            end else if (tmo_hit) begin
              tmo_q <= 1'b1;
              state <= UPDATE_PC;
            end
          end
          WRITEBACK: state <= UPDATE_PC;
          UPDATE_PC: begin
            br_q  <= 1'b0;
            wcnt  <= '0;
            state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

  assign bus.enable_fetch     = run && (state == FETCH);
  assign bus.enable_decode    = run && (state == DECODE);
  assign bus.enable_execute   = run && (state == EXECUTE);
  assign bus.enable_writeback = run && (state == WRITEBACK);
  assign bus.enable_updatePC  = run && (state == UPDATE_PC);
  assign bus.br_taken         = br_q;
  assign bus.timeout_err      = tmo_q;
  assign bus.ctrl_state       = state;

  always_comb begin
    bus.mem_state = 2'b11;
    if (run) begin
      case (state)
        MEM_IND: bus.mem_state = 2'b00;
        MEM_RD:  bus.mem_state = 2'b01;
        MEM_WR:  bus.mem_state = 2'b10;
        default: bus.mem_state = 2'b11;
      endcase
    end
  end

`ifdef LC3_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_count <= '0;
      stall_count <= '0;
    end else if (run) begin
      if (state == UPDATE_PC)
        instr_count <= instr_count + 16'd1;
      if (in_wait && !wait_done && (stall_count != '1))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Scoreboard bench for lc3_ctrl_seq: random instructions and memory delays, with
// per-instruction cycle profile predicted from the instruction rules.
module tb_lc3_ctrl_seq;

  localparam int T   = 4;
  localparam int NUM = 150;
  localparam int ND  = 8;

  typedef struct {
    int total;
    int n_ind;
    int n_rd;
    int n_wr;
    int n_wb;
    int n_tmo;
    int ssum;
    int br;
  } prof_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  lc3_ctrl_seq_if bus();
`ifdef LC3_CTRL_PERF_EN
  logic [15:0] instr_count;
  logic [15:0] stall_count;
`endif

  lc3_ctrl_seq #(.TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LC3_CTRL_PERF_EN
    ,
    .instr_count (instr_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: cycle profile of one instruction from fetch entry to UPDATE_PC.
  function automatic prof_t model(input logic [15:0] ir_v, input logic [2:0] nzp_v,
                                  input int fd, input int di, input int dm);
    prof_t e;
    int    op;
    bit    ok;
    e  = '{default: 0};
    op = int'(ir_v[15:12]);
    e.n_tmo = fd / T;
    ok = 1'b1;
    case (op)
      1, 5, 9, 14: e.n_wb = 1;
      2, 6, 10: begin
        if (op == 10) begin
          if (di < T) e.n_ind = di + 1;
          else begin e.n_ind = T; e.n_tmo++; ok = 1'b0; end
        end
        if (ok) begin
          if (dm < T) begin e.n_rd = dm + 1; e.n_wb = 1; end
          else begin e.n_rd = T; e.n_tmo++; end
        end
      end
      3, 7, 11: begin
        if (op == 11) begin
          if (di < T) e.n_ind = di + 1;
          else begin e.n_ind = T; e.n_tmo++; ok = 1'b0; end
        end
        if (ok) begin
          if (dm < T) e.n_wr = dm + 1;
          else begin e.n_wr = T; e.n_tmo++; end
        end
      end
      0:  e.br = (ir_v[11:9] & nzp_v) != 3'b000 ? 1 : 0;
      12: e.br = 1;
      default: ;
    endcase
    e.total = (fd + 1) + 3 + e.n_ind + e.n_rd + e.n_wr + e.n_wb;
    e.ssum  = 1 + 2 + 7 + 4 * e.n_ind + 5 * e.n_rd + 6 * e.n_wr + 3 * e.n_wb;
    return e;
  endfunction

  logic [15:0] d_ir  [ND] = '{16'h1261, 16'h0405, 16'h0405, 16'hA402,
                              16'hB402, 16'h2000, 16'h2000, 16'h0E00};
  logic [2:0]  d_nzp [ND] = '{3'b000, 3'b010, 3'b100, 3'b001,
                              3'b001, 3'b010, 3'b010, 3'b100};
  int          d_fd  [ND] = '{0, 0, 0, 0, 0, 0, 0, 5};
  int          d_di  [ND] = '{0, 0, 0, 3, 0, 0, 0, 0};
  int          d_dm  [ND] = '{0, 0, 0, 3, 0, 4, 3, 0};

  prof_t exp_q[$];

  bit          drive_on = 1'b0;
  bit          mon_on   = 1'b0;
  int          issued   = 0;
  int          done     = 0;
  int          drv_cyc  = 0;
  bit          drv_prev_fetch = 1'b0;
  logic [1:0]  drv_prev_ms = 2'b11;
  bit          drv_active = 1'b0;
  int          cur_fd, cur_di, cur_dm, dl;
  logic [15:0] nir;
  logic [2:0]  nnzp;

  // Driver: picks the next instruction at each fetch entry and times the
  // completion inputs relative to the cycles spent in the current wait state.
  always @(negedge clk) begin
    if (drive_on) begin
      if (bus.enable_fetch && !drv_prev_fetch) begin
        drv_cyc = 0;
        if (issued < NUM) begin
          if (issued < ND) begin
            nir = d_ir[issued]; nnzp = d_nzp[issued];
            cur_fd = d_fd[issued]; cur_di = d_di[issued]; cur_dm = d_dm[issued];
          end else begin
            nir    = 16'($urandom);
            nnzp   = 3'($urandom_range(0, 7));
            cur_fd = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 2);
            cur_di = $urandom_range(0, 5);
            cur_dm = $urandom_range(0, 5);
          end
          bus.ir  = nir;
          bus.nzp = nnzp;
          exp_q.push_back(model(nir, nnzp, cur_fd, cur_di, cur_dm));
          issued++;
          drv_active = 1'b1;
        end else begin
          drv_active = 1'b0;
        end
      end else if (bus.mem_state != 2'b11 && bus.mem_state != drv_prev_ms) begin
        drv_cyc = 0;
      end else begin
        drv_cyc++;
      end

      if (bus.enable_fetch)
        bus.complete_instr = drv_active && (drv_cyc == cur_fd);
      else
        bus.complete_instr = 1'($urandom_range(0, 1));

      if (bus.mem_state != 2'b11) begin
        dl = (bus.mem_state == 2'b00) ? cur_di : cur_dm;
        bus.complete_data = drv_active && (drv_cyc == dl);
      end else begin
        bus.complete_data = 1'($urandom_range(0, 1));
      end

      drv_prev_fetch = bus.enable_fetch;
      drv_prev_ms    = bus.mem_state;
    end
  end

  prof_t acc;
  prof_t e;
  bit    mon_prev_fetch = 1'b0;

  // Monitor: accumulates the observed profile and scores it at UPDATE_PC.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.enable_fetch && !mon_prev_fetch)
        acc = '{default: 0};
      acc.total++;
      case (bus.mem_state)
        2'b00: acc.n_ind++;
        2'b01: acc.n_rd++;
        2'b10: acc.n_wr++;
        default: ;
      endcase
      if (bus.enable_writeback) acc.n_wb++;
      if (bus.timeout_err)      acc.n_tmo++;
      acc.ssum += int'(bus.ctrl_state);
      if (bus.enable_updatePC) begin
        if (exp_q.size() == 0) begin
          check("unexpected_updatepc", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("cycles",      acc.total, e.total);
          check("mem_ind",     acc.n_ind, e.n_ind);
          check("mem_rd",      acc.n_rd,  e.n_rd);
          check("mem_wr",      acc.n_wr,  e.n_wr);
          check("writeback",   acc.n_wb,  e.n_wb);
          check("timeout_err", acc.n_tmo, e.n_tmo);
          check("state_sum",   acc.ssum,  e.ssum);
          check("br_taken",    int'(bus.br_taken), e.br);
        end
        done++;
      end
      mon_prev_fetch = bus.enable_fetch;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_enables"}, int'({bus.enable_fetch, bus.enable_decode, bus.enable_execute,
                                   bus.enable_writeback, bus.enable_updatePC}), 0);
    check({tag, "_mem_state"}, int'(bus.mem_state), 3);
    check({tag, "_ctrl_state"}, int'(bus.ctrl_state), 0);
    check({tag, "_br_taken"}, int'(bus.br_taken), 0);
    check({tag, "_timeout_err"}, int'(bus.timeout_err), 0);
  endtask

  initial begin
    bus.complete_instr = 1'b0;
    bus.complete_data  = 1'b0;
    bus.ir             = '0;
    bus.nzp            = '0;
    #1;
    check_idle("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset_hold");
`ifdef LC3_CTRL_PERF_EN
    check("reset_instr_count", int'(instr_count), 0);
`endif
    rst      = 1'b1;
    drive_on = 1'b1;
    mon_on   = 1'b1;
    #1;
    check("release_idle_fetch", int'(bus.enable_fetch), 0);
    @(posedge clk);
    #1;
    check("first_fetch", int'(bus.enable_fetch), 1);

    for (int c = 0; c < 20000 && done < NUM; c++)
      @(posedge clk);
    check("instr_done", done, NUM);
    check("queue_empty", exp_q.size(), 0);
    @(negedge clk);
`ifdef LC3_CTRL_PERF_EN
    check("instr_count", int'(instr_count), NUM);
`endif

    drive_on = 1'b0;
    mon_on   = 1'b0;
    bus.ir             = 16'h3000;
    bus.complete_instr = 1'b1;
    bus.complete_data  = 1'b0;
    for (int c = 0; c < 40 && bus.mem_state != 2'b10; c++)
      @(negedge clk);
    check("reach_mem_wr", int'(bus.mem_state), 2);
    rst = 1'b0;
    #1;
    check_idle("midreset");
`ifdef LC3_CTRL_PERF_EN
    check("midreset_instr_count", int'(instr_count), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrel_idle", int'(bus.enable_fetch), 0);
    @(posedge clk);
    #1;
    check("midrel_fetch", int'(bus.enable_fetch), 1);
    check("midrel_state", int'(bus.ctrl_state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
